// File: rtl/cache_refill_mem.sv
// Backing memory behind the set-associative cache: one miss-fill request at a time, answered after LATENCY cycles.
// Define CACHE_REFILL_MEM_WRITE_EN to add req_we/req_wdata, which turn a request into a write that is acknowledged with the written word.
module cache_refill_mem #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int LATENCY       = 3,
    parameter int INIT_IDENTITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
`ifdef CACHE_REFILL_MEM_WRITE_EN
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
`endif
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return (INIT_IDENTITY != 0) ? DATA_W'(a) : '0;
    endfunction

`ifdef CACHE_REFILL_MEM_WRITE_EN
    // Unwritten words fall back to the power-up image, so only writes need storage state.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written = '0;

    always_ff @(posedge clk) begin
        if (rst && state == IDLE && req_valid && req_we) begin
            mem[req_addr]     <= req_wdata;
            written[req_addr] <= 1'b1;
        end
    end

    assign rd_word = written[addr_q] ? mem[addr_q] : init_word(addr_q);
`else
    assign rd_word = init_word(addr_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_addr  <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        cnt       <= CNT_INIT;
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_data  <= rd_word;
                        resp_addr  <= addr_q;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/cache_refill_mem.md
Name: cache_refill_mem

Overview:
- Backing-memory stage directly downstream of the 2-way set-associative cache.
- Services cache miss fills: accepts one read request per transaction over a valid/ready handshake.
- Returns the addressed byte after a fixed, programmable latency, so the cache can model real miss penalty instead of single-cycle fills.
- Array power-up contents are the identity pattern (word i holds value i); this matches the cache's expected data image.

Parameters:
- ADDR_W, 8, request address width; array depth is 2**ADDR_W.
- DATA_W, 8, data word width.
- LATENCY, 3, cycles from the request-acceptance edge to the response-valid edge; legal range 1..15.
- INIT_IDENTITY, 1, 1 = initialise word i to i (truncated to DATA_W); 0 = initialise all words to 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  cache presents a miss-fill request.
- req_addr  in  ADDR_W  address of the requested word.
- req_ready  out  1  block can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; resp_data and resp_addr are valid.
- resp_data  out  DATA_W  returned word.
- resp_addr  out  ADDR_W  address the response belongs to.
- busy  out  1  a transaction is in flight (state is not IDLE).

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE, cnt=0, resp_valid=0, resp_data=0, resp_addr=0, busy=0.
  - The array is not cleared; contents are set only at initialisation.
  - Reset takes priority over every other event.
- States:
  - IDLE: req_ready=1, busy=0. On an edge with req_valid==1: capture req_addr into addr_q, set cnt=LATENCY-1, go to WAIT. With req_valid==0: stay in IDLE.
  - WAIT: req_ready=0, busy=1. On each edge, if cnt!=0 then decrement cnt; if cnt==0 then load resp_data=mem[addr_q] and resp_addr=addr_q, set resp_valid=1, go to RESP.
  - RESP: req_ready=0, busy=1, resp_valid=1 for exactly this cycle. The next edge returns to IDLE with resp_valid=0.
- Latency and throughput:
  - If acceptance occurs at edge e0, resp_valid is high in the cycle following edge e(LATENCY).
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- Handshake rules:
  - A request transfers only on an edge where req_valid and req_ready are both 1.
  - A request raised while the block is busy is not lost; the cache holds req_valid and req_addr until req_ready is seen.
  - req_addr changing while not accepted has no effect.
  - There is no response back-pressure; the cache must consume resp_data in the resp_valid cycle.
- resp_data and resp_addr hold their last values after the response pulse until the next response or reset.
- cnt width is 4 bits, so LATENCY=15 gives cnt=14 and no overflow. LATENCY=1 gives cnt=0, and WAIT lasts exactly one edge.
- Reset mid-operation (in WAIT or RESP) aborts the transaction. No resp_valid is produced for it, and the next cycle shows req_ready=1.
- Edge case: req_valid asserted in the same cycle as rst==0 is not accepted.

Optional Feature:
- Macro: CACHE_REFILL_MEM_WRITE_EN
- With the macro defined:
  - Adds ports req_we (in, 1) and req_wdata (in, DATA_W).
  - A request with req_we==1 writes mem[req_addr]=req_wdata at the acceptance edge.
  - It then follows the same WAIT/RESP timing; the response pulse carries resp_data=the written value as a write acknowledge.
  - A later read of that address returns the new value.
- Without the macro: the ports are absent, every request is a read, and the array is read-only after initialisation.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=1 -> req_ready=1, busy=0, resp_valid=0, resp_data=0, and no transaction is accepted.
- Single read (LATENCY=3): req_addr=0x5A accepted at edge e0 -> resp_valid=1 only after e3, resp_data=0x5A, resp_addr=0x5A; in IDLE after e4.
- Busy hold-off: accept 0x10, then hold req_valid=1 with req_addr=0x22 -> req_ready=0 through RESP; 0x22 accepted on the first IDLE edge; responses are 0x10 then 0x22, with no duplicate.
- Reset mid-WAIT: accept 0xF0, drive rst=0 one cycle later -> no resp_valid ever; next IDLE request for 0x03 returns 0x03.
- LATENCY=1 back-to-back: continuous requests for 0x00, 0x01, 0x02 -> one response every 3 cycles, each returning data equal to its address.
- (Macro defined) write 0xC3 to address 0x10, then read 0x10 -> write ack resp_data=0xC3, read resp_data=0xC3; address 0x11 still returns 0x11.
